// File: rtl/debug_pipe_ctrl.sv
// Debug sequencer for the 5-stage pipeline. It runs, steps or halts the core
// from debug commands. While the core is stopped it scans the register file
// and then the cycle counter out over a valid/ready stream.
module debug_pipe_ctrl #(
  parameter int unsigned LEN     = 32,
  parameter int unsigned NB_REG  = 32,
  parameter int unsigned NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_halt_instr,
  output logic               o_pipe_en,
  output logic               o_dbg_sel,
  output logic [NB_ADDR-1:0] o_dbg_reg_addr,
  input  logic [LEN-1:0]     i_dbg_reg_data,
  output logic               o_data_valid,
  output logic [LEN-1:0]     o_data,
  input  logic               i_data_ready,
  output logic [LEN-1:0]     o_cycle_count,
  output logic               o_prog_done
);

  // One extra index bit lets NB_REG == 2**NB_ADDR reach the count slot without wrapping
  localparam int unsigned IDX_W = NB_ADDR + 1;

  localparam logic [1:0] CMD_HALT = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_DUMP = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_last;
  logic               r_data_valid;
  logic [LEN-1:0]     r_data;
  logic [LEN-1:0]     r_cycle_count;
  logic               r_prog_done;

  logic               w_cmd_fire;
  logic               w_load;
  logic               w_last_acc;
  logic               w_dump_entry;

  assign w_cmd_fire   = i_cmd_valid && o_cmd_ready;
  assign w_load       = (r_state == S_DUMP) && !r_last && (!r_data_valid || i_data_ready);
  assign w_last_acc   = (r_state == S_DUMP) && r_last && r_data_valid && i_data_ready;
  assign w_dump_entry = (r_state != S_DUMP) && (w_next_state == S_DUMP);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a HALT opcode in RUN outranks any simultaneous command
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          case (i_cmd)
            CMD_RUN:  w_next_state = r_prog_done ? S_IDLE : S_RUN;
            CMD_STEP: w_next_state = r_prog_done ? S_IDLE : S_STEP;
            CMD_DUMP: w_next_state = S_DUMP;
            default:  w_next_state = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt_instr) begin
          w_next_state = S_IDLE;
        end else if (w_cmd_fire && (i_cmd == CMD_HALT)) begin
          w_next_state = S_IDLE;
        end
      end
      S_STEP: begin
        w_next_state = S_IDLE;
      end
      S_DUMP: begin
        if (w_last_acc) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    o_cmd_ready    = 1'b0;
    o_pipe_en      = 1'b0;
    o_dbg_sel      = 1'b0;
    o_dbg_reg_addr = '0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
      end
      S_RUN: begin
        o_cmd_ready = 1'b1;
        o_pipe_en   = 1'b1;
      end
      S_STEP: begin
        o_pipe_en = 1'b1;
      end
      S_DUMP: begin
        o_dbg_sel      = 1'b1;
        o_dbg_reg_addr = r_idx[NB_ADDR-1:0];
      end
      default: ;
    endcase
  end

  // Saturating count of enabled cycles and sticky program-done flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle_count <= '0;
      r_prog_done   <= 1'b0;
    end else begin
      if (o_pipe_en && (r_cycle_count != {LEN{1'b1}})) begin
        r_cycle_count <= r_cycle_count + LEN'(1);
      end
      if (o_pipe_en && i_halt_instr) begin
        r_prog_done <= 1'b1;
      end
    end
  end

  // Dump scanner: registers in order, then the cycle count, each held until taken
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx        <= '0;
      r_last       <= 1'b0;
      r_data_valid <= 1'b0;
      r_data       <= '0;
    end else if (w_dump_entry) begin
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      if (r_idx == IDX_W'(NB_REG)) begin
        r_data <= r_cycle_count;
        r_last <= 1'b1;
      end else begin
        r_data <= i_dbg_reg_data;
        r_idx  <= r_idx + IDX_W'(1);
      end
      r_data_valid <= 1'b1;
    end else if (w_last_acc) begin
      r_data_valid <= 1'b0;
      r_last       <= 1'b0;
    end
  end

  assign o_data_valid  = r_data_valid;
  assign o_data        = r_data;
  assign o_cycle_count = r_cycle_count;
  assign o_prog_done   = r_prog_done;

endmodule

// File: tb/tb_debug_pipe_ctrl.sv
// Directed bench for debug_pipe_ctrl: vector tables for run/step control and
// hand-written sequences for register dumps and reset during a dump.
module tb_debug_pipe_ctrl;

  localparam int unsigned LEN     = 32;
  localparam int unsigned NB_REG  = 32;
  localparam int unsigned NB_ADDR = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic [1:0]         cmd;
  logic               cmd_ready;
  logic               halt_instr;
  logic               pipe_en;
  logic               dbg_sel;
  logic [NB_ADDR-1:0] dbg_reg_addr;
  logic [LEN-1:0]     dbg_reg_data;
  logic               data_valid;
  logic [LEN-1:0]     data;
  logic               data_ready;
  logic [LEN-1:0]     cycle_count;
  logic               prog_done;

  logic [LEN-1:0]     rf [NB_REG];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        cv;
    logic [1:0]  cmd;
    logic        hi;
    logic        pe;
    logic        rdy;
    logic [31:0] cnt;
    logic        done;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  // Register file model: combinational read, poisoned when the port is not borrowed
  assign dbg_reg_data = dbg_sel ? rf[dbg_reg_addr] : 32'hDEAD_BEEF;

  debug_pipe_ctrl #(.LEN(LEN), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cmd_valid    (cmd_valid),
    .i_cmd          (cmd),
    .o_cmd_ready    (cmd_ready),
    .i_halt_instr   (halt_instr),
    .o_pipe_en      (pipe_en),
    .o_dbg_sel      (dbg_sel),
    .o_dbg_reg_addr (dbg_reg_addr),
    .i_dbg_reg_data (dbg_reg_data),
    .o_data_valid   (data_valid),
    .o_data         (data),
    .i_data_ready   (data_ready),
    .o_cycle_count  (cycle_count),
    .o_prog_done    (prog_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void addv(input logic cv, input logic [1:0] c, input logic hi,
                               input logic pe, input logic rdy, input logic [31:0] cnt,
                               input logic done);
    vec_t v;
    v.cv = cv; v.cmd = c; v.hi = hi; v.pe = pe; v.rdy = rdy; v.cnt = cnt; v.done = done;
    vq.push_back(v);
  endfunction

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      cmd_valid  = vq[i].cv;
      cmd        = vq[i].cmd;
      halt_instr = vq[i].hi;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d] pipe_en", tag, i), 32'(pipe_en), 32'(vq[i].pe));
      check($sformatf("%s[%0d] cmd_ready", tag, i), 32'(cmd_ready), 32'(vq[i].rdy));
      check($sformatf("%s[%0d] cycle_count", tag, i), cycle_count, vq[i].cnt);
      check($sformatf("%s[%0d] prog_done", tag, i), 32'(prog_done), 32'(vq[i].done));
    end
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd        = 2'b00;
    halt_instr = 1'b0;
    vq.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " data_valid"}, 32'(data_valid), 32'd0);
    check({tag, " dbg_sel"}, 32'(dbg_sel), 32'd0);
    check({tag, " cycle_count"}, cycle_count, 32'd0);
    check({tag, " prog_done"}, 32'(prog_done), 32'd0);
    check({tag, " pipe_en"}, 32'(pipe_en), 32'd0);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  // Issue DUMP and consume words; slow=1 accepts only every third cycle.
  // abort_at>0 returns (with the stream live) once that many words were taken.
  task automatic do_dump(input string tag, input bit slow, input logic [31:0] exp_cnt,
                         input int abort_at);
    int          n       = 0;
    int          cyc     = 0;
    bit          stalled = 1'b0;
    bit          aborted = 1'b0;
    logic [31:0] held    = '0;
    logic [31:0] exp;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd        = 2'b11;
    data_ready = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " entry dbg_sel"}, 32'(dbg_sel), 32'd1);
    check({tag, " entry cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, " entry pipe_en"}, 32'(pipe_en), 32'd0);
    check({tag, " entry data_valid"}, 32'(data_valid), 32'd0);
    while (n < int'(NB_REG) + 1 && cyc < 500 && !aborted) begin
      @(negedge clk);
      cmd_valid  = 1'b0;
      cyc++;
      data_ready = slow ? ((cyc % 3) == 0) : 1'b1;
      if (stalled) begin
        check($sformatf("%s hold valid w%0d", tag, n), 32'(data_valid), 32'd1);
        check($sformatf("%s hold data w%0d", tag, n), data, held);
      end
      if (data_valid && data_ready) begin
        exp = (n < int'(NB_REG)) ? rf[n] : exp_cnt;
        check($sformatf("%s word%0d", tag, n), data, exp);
        n++;
        stalled = 1'b0;
        if (abort_at > 0 && n == abort_at) aborted = 1'b1;
      end else begin
        stalled = data_valid;
        held    = data;
      end
    end
    if (!aborted) begin
      check({tag, " words taken"}, 32'(n), 32'(NB_REG + 1));
      @(posedge clk);
      #1;
      check({tag, " end data_valid"}, 32'(data_valid), 32'd0);
      check({tag, " end cmd_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, " end dbg_sel"}, 32'(dbg_sel), 32'd0);
      @(negedge clk);
      data_ready = 1'b0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd        = 2'b00;
    halt_instr = 1'b0;
    data_ready = 1'b0;
    for (int k = 0; k < int'(NB_REG); k++) rf[k] = 32'(k * 32'h11);

    repeat (2) @(posedge clk);
    #1;
    reset_checks("in reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    reset_checks("after reset");

    // Three single steps, then a run stopped by the HALT opcode on its 10th enabled cycle
    addv(1, 2'b10, 0, 1, 0, 0, 0);
    addv(0, 2'b00, 0, 0, 1, 1, 0);
    addv(1, 2'b10, 0, 1, 0, 1, 0);
    addv(0, 2'b00, 0, 0, 1, 2, 0);
    addv(1, 2'b10, 0, 1, 0, 2, 0);
    addv(0, 2'b00, 0, 0, 1, 3, 0);
    addv(1, 2'b00, 0, 0, 1, 3, 0);
    addv(1, 2'b01, 0, 1, 1, 3, 0);
    for (int k = 1; k <= 9; k++) begin
      addv(k == 3, 2'b01, 0, 1, 1, 32'(3 + k), 0);
    end
    addv(0, 2'b00, 1, 0, 1, 13, 1);
    addv(1, 2'b01, 0, 0, 1, 13, 1);
    addv(1, 2'b10, 0, 0, 1, 13, 1);
    run_vectors("steprun");

    do_dump("fast", 1'b0, 32'd13, 0);
    do_dump("slow", 1'b1, 32'd13, 0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    reset_checks("rst2");
    @(negedge clk);
    rst = 1'b0;

    // HALT command stops a run; then HALT command coincides with the HALT opcode
    addv(1, 2'b01, 0, 1, 1, 0, 0);
    addv(0, 2'b00, 0, 1, 1, 1, 0);
    addv(1, 2'b01, 0, 1, 1, 2, 0);
    addv(1, 2'b00, 0, 0, 1, 3, 0);
    addv(1, 2'b01, 0, 1, 1, 3, 0);
    addv(0, 2'b00, 0, 1, 1, 4, 0);
    addv(1, 2'b00, 1, 0, 1, 5, 1);
    addv(1, 2'b10, 0, 0, 1, 5, 1);
    run_vectors("halt");

    do_dump("abort", 1'b0, 32'd5, 5);
    rst = 1'b1;
    #1;
    reset_checks("mid-dump rst");
    @(negedge clk);
    rst        = 1'b0;
    data_ready = 1'b0;

    do_dump("restart", 1'b0, 32'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
